// File: rtl/point_cloud_streamer.sv
// point_cloud_streamer: for each stored point, fetches it as target, streams the whole cloud to the validator core, returns one verdict per point.
// Build option SKIP_SELF_EN pads the lane holding the current target so a point never matches itself.
module point_cloud_streamer #(
    parameter int N                = 16,
    parameter int DISTANCE_MODULES = 8,
    parameter int ADDR_W           = 16,
    parameter int RD_LATENCY       = 1,
    parameter int DRAIN_CYCLES     = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [2*N-1:0]                    point_cloud_size,
    output logic                              busy,
    output logic                              done,
    output logic                              tgt_rd_en,
    output logic [ADDR_W-1:0]                 tgt_addr,
    input  logic [3*N-1:0]                    tgt_rd_data,
    output logic                              blk_rd_en,
    output logic [ADDR_W-1:0]                 blk_addr,
    input  logic [3*N*DISTANCE_MODULES-1:0]   blk_rd_data,
    output logic [N-1:0]                      point_x,
    output logic [N-1:0]                      point_y,
    output logic [N-1:0]                      point_z,
    output logic [N*DISTANCE_MODULES-1:0]     cp_x,
    output logic [N*DISTANCE_MODULES-1:0]     cp_y,
    output logic [N*DISTANCE_MODULES-1:0]     cp_z,
    output logic                              core_reset,
    input  logic                              inlier,
    input  logic                              outlier,
    output logic                              res_valid,
    output logic [ADDR_W-1:0]                 res_index,
    output logic                              res_inlier,
    input  logic                              res_ready
);
    localparam int DM = DISTANCE_MODULES;
    localparam int PW = ADDR_W + 1;
    localparam int CW = $clog2(RD_LATENCY + DRAIN_CYCLES + 1);
    localparam int DW = N * DM;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STREAM, DRAIN, EMIT} state_t;

    state_t                              state_q, state_d;
    logic [PW-1:0]                       p_q, p_d, nb_q, nb_d, p_in;
    logic [ADDR_W-1:0]                   t_q, t_d, b_q, b_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic [RD_LATENCY-1:0]               vld_q, vld_d;
    logic [RD_LATENCY-1:0][ADDR_W-1:0]   ba_q, ba_d;
    logic [N-1:0]                        px_q, px_d, py_q, py_d, pz_q, pz_d;
    logic [DW-1:0]                       cx_q, cx_d, cy_q, cy_d, cz_q, cz_d;
    logic [DW-1:0]                       ret_x, ret_y, ret_z;
    logic                                res_inl_q, res_inl_d, done_q, done_d;
    logic                                hs, last_tgt, last_blk, cap, unused_size_hi;

    assign p_in           = PW'(point_cloud_size);
    assign unused_size_hi = ^point_cloud_size[2*N-1:PW];
    assign hs             = state_q == EMIT && res_ready;
    assign last_tgt       = {1'b0, t_q} == p_q - PW'(1);
    assign last_blk       = {1'b0, b_q} == nb_q - PW'(1);
    // Returning data is dropped once a verdict has been seen or the pass left STREAM/DRAIN.
    assign cap            = vld_q[RD_LATENCY-1] && !inlier;

    for (genvar k = 0; k < DM; k++) begin : g_lane
        logic [PW:0] idx;
        logic        pad;
        assign idx = (PW+1)'(ba_q[RD_LATENCY-1]) * (PW+1)'(DM) + (PW+1)'(k);
`ifdef SKIP_SELF_EN
        assign pad = idx >= (PW+1)'(p_q) || idx == (PW+1)'(t_q);
`else
        assign pad = idx >= (PW+1)'(p_q);
`endif
        assign ret_x[k*N +: N] = pad ? '1 : blk_rd_data[3*N*k +: N];
        assign ret_y[k*N +: N] = pad ? '1 : blk_rd_data[3*N*k + N +: N];
        assign ret_z[k*N +: N] = pad ? '1 : blk_rd_data[3*N*k + 2*N +: N];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && p_in != '0) state_d = FETCH;
            FETCH:   if (cnt_q == CW'(RD_LATENCY - 1)) state_d = LOAD;
            LOAD:    state_d = STREAM;
            STREAM:  state_d = inlier ? EMIT : last_blk ? DRAIN : STREAM;
            DRAIN:   if (inlier || outlier || cnt_q == CW'(RD_LATENCY + DRAIN_CYCLES - 1)) state_d = EMIT;
            EMIT:    if (res_ready) state_d = last_tgt ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = state_q != IDLE;
        done       = done_q;
        tgt_rd_en  = state_q == FETCH && cnt_q == '0;
        tgt_addr   = t_q;
        blk_rd_en  = state_q == STREAM;
        blk_addr   = b_q;
        point_x    = px_q;
        point_y    = py_q;
        point_z    = pz_q;
        cp_x       = cx_q;
        cp_y       = cy_q;
        cp_z       = cz_q;
        core_reset = !(state_q == STREAM || state_q == DRAIN);
        res_valid  = state_q == EMIT;
        res_index  = t_q;
        res_inlier = res_inl_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_q       <= '0;
            nb_q      <= '0;
            t_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            vld_q     <= '0;
            ba_q      <= '0;
            px_q      <= '0;
            py_q      <= '0;
            pz_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            cz_q      <= '0;
            res_inl_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            p_q       <= p_d;
            nb_q      <= nb_d;
            t_q       <= t_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            vld_q     <= vld_d;
            ba_q      <= ba_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pz_q      <= pz_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            cz_q      <= cz_d;
            res_inl_q <= res_inl_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        p_d       = (state_q == IDLE && start) ? p_in : p_q;
        nb_d      = (state_q == IDLE && start) ? (p_in + PW'(DM - 1)) / PW'(DM) : nb_q;
        t_d       = (state_q == IDLE) ? '0 : (hs && !last_tgt) ? t_q + ADDR_W'(1) : t_q;
        b_d       = (state_q == LOAD) ? '0 : (state_q == STREAM) ? b_q + ADDR_W'(1) : b_q;
        cnt_d     = (state_d != state_q) ? '0 : cnt_q + CW'(1);
        vld_d     = (state_d == STREAM || state_d == DRAIN) ? RD_LATENCY'({vld_q, blk_rd_en}) : '0;
        ba_d      = (RD_LATENCY*ADDR_W)'({ba_q, b_q});
        px_d      = (state_q == LOAD) ? tgt_rd_data[N-1:0] : px_q;
        py_d      = (state_q == LOAD) ? tgt_rd_data[2*N-1:N] : py_q;
        pz_d      = (state_q == LOAD) ? tgt_rd_data[3*N-1:2*N] : pz_q;
        cx_d      = cap ? ret_x : cx_q;
        cy_d      = cap ? ret_y : cy_q;
        cz_d      = cap ? ret_z : cz_q;
        res_inl_d = (state_d == EMIT && state_q != EMIT) ? inlier : res_inl_q;
        done_d    = (state_q == IDLE && start && p_in == '0) || (hs && last_tgt);
    end
endmodule

// File: tb/tb_point_cloud_streamer.sv
// tb_point_cloud_streamer: directed vector bench with a BRAM model and a scripted validator-core model.
// Honours SKIP_SELF_EN when computing expected comparison lanes.
module tb_point_cloud_streamer;
    localparam int N = 16, DM = 8, AW = 16;
`ifdef SKIP_SELF_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic               clock = 1'b0, reset = 1'b1, start = 1'b0, res_ready = 1'b1;
    logic [2*N-1:0]     point_cloud_size = '0;
    logic               busy, done, tgt_rd_en, blk_rd_en, core_reset, inlier, outlier, res_valid, res_inlier;
    logic [AW-1:0]      tgt_addr, blk_addr, res_index;
    logic [3*N-1:0]     tgt_rd_data = '0;
    logic [3*N*DM-1:0]  blk_rd_data = '0;
    logic [N-1:0]       point_x, point_y, point_z;
    logic [N*DM-1:0]    cp_x, cp_y, cp_z;
    logic [7:0]         gap = '0, nblk = '0;
    logic               exp_inl = 1'b0;
    int n_chk = 0, n_fail = 0;
    int mode = 0, cur_p = 0, exp_idx = 0, exp_str = 0, strobes = 0;
    int n_res = 0, n_done = 0, n_tgt = 0, n_blk = 0, b_last = 0;

    typedef struct { int p; int mode; logic inl; int str; } vec_t;
    vec_t vecs[6];

    point_cloud_streamer dut (
        .clock(clock), .reset(reset), .start(start), .point_cloud_size(point_cloud_size),
        .busy(busy), .done(done), .tgt_rd_en(tgt_rd_en), .tgt_addr(tgt_addr), .tgt_rd_data(tgt_rd_data),
        .blk_rd_en(blk_rd_en), .blk_addr(blk_addr), .blk_rd_data(blk_rd_data),
        .point_x(point_x), .point_y(point_y), .point_z(point_z), .cp_x(cp_x), .cp_y(cp_y), .cp_z(cp_z),
        .core_reset(core_reset), .inlier(inlier), .outlier(outlier), .res_valid(res_valid),
        .res_index(res_index), .res_inlier(res_inlier), .res_ready(res_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [47:0] pt(input int i);
        return {16'(3*i+3), 16'(3*i+2), 16'(3*i+1)};
    endfunction

    function automatic logic [127:0] exp_cp(input int b, input int t, input int p, input int c);
        logic [127:0] v;
        logic [47:0]  q;
        for (int k = 0; k < DM; k++) begin
            int idx;
            idx = b*DM + k;
            q = pt(idx);
            v[16*k +: 16] = (idx >= p || (SKIP && idx == t)) ? 16'hffff : q[16*c +: 16];
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // BRAM with one cycle of read latency
    always @(posedge clock) begin
        if (tgt_rd_en) tgt_rd_data <= pt(int'(tgt_addr));
        if (blk_rd_en) for (int k = 0; k < DM; k++) blk_rd_data[3*N*k +: 3*N] <= pt(int'(blk_addr)*DM + k);
    end

    // Core model: mode 1 outlier / mode 3 both on the third drain cycle, mode 2 inlier after three batches, mode 0 silent
    always @(posedge clock) begin
        gap  <= blk_rd_en ? 8'd0 : gap + 8'd1;
        nblk <= core_reset ? 8'd0 : nblk + {7'd0, blk_rd_en};
    end
    assign inlier  = !core_reset && ((mode == 2 && nblk == 8'd3) || (mode == 3 && !blk_rd_en && gap == 8'd2));
    assign outlier = !core_reset && (mode == 1 || mode == 3) && !blk_rd_en && gap == 8'd2;

    always @(negedge clock) begin
        if (!reset) begin
            if (blk_rd_en) begin
                check("blk_addr", 128'(blk_addr), 128'(strobes));
                strobes++;
                n_blk++;
            end
            if (tgt_rd_en) begin
                check("tgt_addr", 128'(tgt_addr), 128'(exp_idx));
                n_tgt++;
            end
            if (res_valid) check("core_reset_in_emit", 128'(core_reset), 128'(1));
            if (outlier) begin
                b_last = (cur_p + DM - 1) / DM - 1;
                check("cp_x", cp_x, exp_cp(b_last, exp_idx, cur_p, 0));
                check("cp_y", cp_y, exp_cp(b_last, exp_idx, cur_p, 1));
                check("cp_z", cp_z, exp_cp(b_last, exp_idx, cur_p, 2));
                check("point_xyz", 128'({point_z, point_y, point_x}), 128'(pt(exp_idx)));
            end
            if (res_valid && res_ready) begin
                check("res_index", 128'(res_index), 128'(exp_idx));
                check("res_inlier", 128'(res_inlier), 128'(exp_inl));
                check("blk_strobes", 128'(strobes), 128'(exp_str));
                strobes = 0;
                exp_idx++;
                n_res++;
            end
            if (done) begin
                n_done++;
                check("busy_at_done", 128'(busy), 128'(0));
            end
        end
    end

    task automatic kick(input int p, input int md, input logic inl, input int str);
        mode = md; cur_p = p; exp_inl = inl; exp_str = str;
        exp_idx = 0; strobes = 0; n_res = 0; n_done = 0; n_tgt = 0; n_blk = 0;
        @(posedge clock); #1 start = 1'b1; point_cloud_size = 32'(p);
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic finish_run(input int p);
        int cyc = 0;
        while (n_done == 0 && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        check("done_seen", 128'(n_done), 128'(1));
        check("n_results", 128'(n_res), 128'(p));
    endtask

    task automatic check_rst();
        check("rst_ctrl", 128'({busy, done, tgt_rd_en, blk_rd_en, core_reset, res_valid, res_inlier}), 128'(7'b0000100));
        check("rst_addr", 128'({tgt_addr, blk_addr, res_index}), 128'(0));
        check("rst_point", 128'({point_x, point_y, point_z}), 128'(0));
        check("rst_cp_x", cp_x, 128'(0));
        check("rst_cp_y", cp_y, 128'(0));
        check("rst_cp_z", cp_z, 128'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0] = '{8,  1, 1'b0, 1};
        vecs[1] = '{10, 0, 1'b0, 2};
        vecs[2] = '{64, 2, 1'b1, 4};
        vecs[3] = '{3,  3, 1'b1, 1};
        vecs[4] = '{17, 1, 1'b0, 3};
        vecs[5] = '{1,  0, 1'b0, 1};

        @(negedge clock);
        check_rst();
        @(posedge clock); #1 reset = 1'b0;

        kick(0, 0, 1'b0, 0);
        @(negedge clock);
        check("size0_done", 128'(done), 128'(1));
        check("size0_busy", 128'(busy), 128'(0));
        @(negedge clock);
        check("size0_done_pulse", 128'(done), 128'(0));
        repeat (3) @(negedge clock);
        check("size0_reads", 128'(n_tgt + n_blk), 128'(0));
        check("size0_results", 128'(n_res), 128'(0));

        for (int i = 0; i < 6; i++) begin
            kick(vecs[i].p, vecs[i].mode, vecs[i].inl, vecs[i].str);
            finish_run(vecs[i].p);
        end

        @(posedge clock); #1 res_ready = 1'b0;
        kick(3, 1, 1'b0, 1);
        cyc = 0;
        while (!res_valid && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 128'({res_valid, res_index, res_inlier, tgt_rd_en}), 128'({1'b1, 16'd0, 1'b0, 1'b0}));
            @(negedge clock);
        end
        @(posedge clock); #1 res_ready = 1'b1;
        finish_run(3);

        kick(32, 0, 1'b0, 4);
        cyc = 0;
        while (!(blk_rd_en && blk_addr == 16'd2) && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        check("abort_reached_stream", 128'(blk_rd_en), 128'(1));
        #1 reset = 1'b1;
        @(negedge clock);
        check_rst();
        @(posedge clock); #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("abort_no_done", 128'({done, busy}), 128'(0));
        end
        kick(4, 1, 1'b0, 1);
        finish_run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
